// File: rtl/red_pitaya_na_sweep_averager.sv
// Network-analyzer sweep engine: steps the fgen frequency word, lets the
// analog chain settle, integrates NCH demodulated quadratures per point and
// queues {point index, sums} in a first-word-fall-through result FIFO.
module red_pitaya_na_sweep_averager #(
  parameter int NCH       = 2,
  parameter int INBITS    = 24,
  parameter int SUMBITS   = 62,
  parameter int PHASEBITS = 32,
  parameter int CNTBITS   = 32,
  parameter int FIFOLOG2  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [PHASEBITS-1:0]     f_start_i,
  input  logic [PHASEBITS-1:0]     f_step_i,
  input  logic [CNTBITS-1:0]       n_points_i,
  input  logic [CNTBITS-1:0]       sleep_i,
  input  logic [CNTBITS-1:0]       avg_i,
  input  logic [NCH*INBITS-1:0]    dat_i,
  output logic [PHASEBITS-1:0]     freq_o,
  output logic                     freq_upd_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [NCH*SUMBITS-1:0]   res_data_o,
  output logic [CNTBITS-1:0]       res_index_o
);

  localparam int DEPTH = 1 << FIFOLOG2;
  localparam int CW    = FIFOLOG2 + 1;
  localparam int SW    = NCH * SUMBITS;
  localparam int EW    = CNTBITS + SW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SLEEP = 3'd1;
  localparam logic [2:0] S_AVG   = 3'd2;
  localparam logic [2:0] S_PUSH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Widen one signed quadrature to accumulator width.
  function automatic logic signed [SUMBITS-1:0] sext(input logic signed [INBITS-1:0] x);
    return {{(SUMBITS-INBITS){x[INBITS-1]}}, x};
  endfunction

  logic [2:0]                state;
  logic [CNTBITS-1:0]        cnt;
  logic [CNTBITS-1:0]        idx;
  logic [CNTBITS-1:0]        n_lat;
  logic [CNTBITS-1:0]        sleep_lat;
  logic [CNTBITS-1:0]        avg_lat;
  logic [PHASEBITS-1:0]      step_lat;
  logic signed [SUMBITS-1:0] sum [NCH];
  logic [SW-1:0]             sums_flat;

  logic [EW-1:0]             mem [DEPTH];
  logic [FIFOLOG2-1:0]       wr_ptr;
  logic [FIFOLOG2-1:0]       rd_ptr;
  logic [CW-1:0]             count;
  logic                      full;
  logic                      wr_en;
  logic                      rd_en;
  logic [EW-1:0]             head;

  assign full        = (count == FULL_CNT);
  assign wr_en       = (state == S_PUSH) && !full && !abort_i && !rst_i;
  assign res_valid_o = (count != '0);
  assign rd_en       = res_valid_o && res_ready_i;
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign head        = mem[rd_ptr];
  // Empty FIFO presents zeros rather than stale storage.
  assign res_data_o  = res_valid_o ? head[SW-1:0] : '0;
  assign res_index_o = res_valid_o ? head[EW-1:SW] : '0;

  // Flatten per-channel sums, ch0 in the LSBs.
  always_comb begin
    sums_flat = '0;
    for (int c = 0; c < NCH; c++) begin
      sums_flat[c*SUMBITS +: SUMBITS] = sum[c];
    end
  end

  // Sweep sequencer: settle, integrate, push, advance frequency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      n_lat      <= '0;
      sleep_lat  <= '0;
      avg_lat    <= '0;
      step_lat   <= '0;
      freq_o     <= '0;
      freq_upd_o <= 1'b0;
      for (int c = 0; c < NCH; c++) sum[c] <= '0;
    end else begin
      freq_upd_o <= 1'b0;
      if (abort_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              n_lat     <= n_points_i;
              sleep_lat <= sleep_i;
              avg_lat   <= avg_i;
              step_lat  <= f_step_i;
              if (n_points_i == '0) begin
                state <= S_DONE;
              end else begin
                freq_o     <= f_start_i;
                freq_upd_o <= 1'b1;
                idx        <= '0;
                cnt        <= sleep_i;
                for (int c = 0; c < NCH; c++) sum[c] <= '0;
                state      <= S_SLEEP;
              end
            end
          end
          S_SLEEP: begin
            if (cnt == '0) begin
              cnt   <= avg_lat;
              state <= S_AVG;
            end else begin
              cnt <= cnt - CNTBITS'(1);
            end
          end
          S_AVG: begin
            // cnt holds samples still to take; zero means an empty average.
            if (cnt != '0) begin
              for (int c = 0; c < NCH; c++) begin
                sum[c] <= sum[c] + sext(dat_i[c*INBITS +: INBITS]);
              end
              cnt <= cnt - CNTBITS'(1);
            end
            if (cnt <= CNTBITS'(1)) state <= S_PUSH;
          end
          S_PUSH: begin
            // Held here while the FIFO is full; the sweep simply pauses.
            if (!full) begin
              if (idx == n_lat - CNTBITS'(1)) begin
                state <= S_DONE;
              end else begin
                idx        <= idx + CNTBITS'(1);
                freq_o     <= freq_o + step_lat;
                freq_upd_o <= 1'b1;
                cnt        <= sleep_lat;
                for (int c = 0; c < NCH; c++) sum[c] <= '0;
                state      <= S_SLEEP;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; abort discards everything queued.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFOLOG2'(1);
      if (rd_en) rd_ptr <= rd_ptr + FIFOLOG2'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, data only.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= {idx, sums_flat};
  end

endmodule
